sprite_cmd_sched: RTL and testbench

Frame-synchronous command scheduler between the Avalon slave and the sprite display units inside the PPU. It buffers CPU sprite-register writes in a FIFO. Committed writes are released to the shared sprite write bus only during vertical blanking, so sprite position, shape and enable state never change mid-frame (no tearing). Its sprite_wdata/sprite_wvalid outputs replace the raw writedata fan-out to the *_display units.

---
 rtl/ppu_pkg.sv | 22 ++
 rtl/sprite_cmd_fifo.sv | 78 +++++++
 rtl/sprite_cmd_sched.sv | 153 +++++++++++++++
 tb/tb_sprite_cmd_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: frame timing, colour key, scheduler states and
// the Avalon register map used by the sprite command scheduler.
package ppu_pkg;

    // First vcount value that belongs to vertical blanking.
    localparam int VACTIVE_DEFAULT = 480;

    // Transparent/background colour used by the sprite display units.
    localparam logic [23:0] BG_KEY = 24'h9290ff;

    // Avalon register map of the scheduler.
    localparam logic [2:0] ADDR_PUSH   = 3'd0;
    localparam logic [2:0] ADDR_COMMIT = 3'd1;
    localparam logic [2:0] ADDR_FLUSH  = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Single-clock first-word-fall-through FIFO holding sprite command words.
// Flush has priority over push and pop. A push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module sprite_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == CNT_W'(DEPTH));
    assign level   = level_q;
    assign dout    = mem[rd_ptr_q];
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; occupancy gates every read, so stale contents are never observed.
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sprite_cmd_sched.sv
// Frame-synchronous sprite command scheduler. CPU writes are queued in a
// FIFO; a commit marks how many queued words form the next batch, and that
// batch is broadcast to the sprite display units only during vertical
// blanking, so sprite state never changes mid-frame.
module sprite_cmd_sched
    import ppu_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int VACTIVE = VACTIVE_DEFAULT,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write,
    input  logic [2:0]       address,
    input  logic [31:0]      writedata,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    output logic [31:0]      sprite_wdata,
    output logic             sprite_wvalid,
    output logic [CNT_W-1:0] fifo_level,
    output logic             overflow,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [9:0] VACTIVE_V = 10'(VACTIVE);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
    logic             in_vblank_q;
    logic             overflow_q, overflow_d;
    logic [31:0]      sprite_wdata_q, sprite_wdata_d;
    logic             sprite_wvalid_q, sprite_wvalid_d;
    logic             frame_done_q, frame_done_d;

    logic             wr_en, push_req, commit_req, flush_req;
    logic             in_vblank, vb_rise;
    logic             pop, push_ok;
    logic             fifo_full, fifo_empty;
    logic [31:0]      fifo_dout;
    logic [CNT_W-1:0] cnt_after_pop;

    // Horizontal position plays no part in frame timing.
    logic             unused_hcount;
    assign unused_hcount = ^hcount;

    assign wr_en      = chipselect & write;
    assign push_req   = wr_en && (address == ADDR_PUSH);
    assign commit_req = wr_en && (address == ADDR_COMMIT);
    assign flush_req  = wr_en && (address == ADDR_FLUSH);

    assign in_vblank  = (vcount >= VACTIVE_V);
    assign vb_rise    = in_vblank & ~in_vblank_q;

    // One word leaves per cycle while a committed batch is pending in vblank.
    assign pop = (state_q == DRAIN) && in_vblank && (commit_cnt_q != '0)
                 && !fifo_empty && !flush_req;
    assign push_ok       = push_req && (!fifo_full || pop);
    assign cnt_after_pop = fifo_level - CNT_W'(pop);

    sprite_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .flush (flush_req),
        .din   (writedata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Register stage: FSM state, batch counter, vblank history and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            commit_cnt_q    <= '0;
            in_vblank_q     <= 1'b0;
            overflow_q      <= 1'b0;
            sprite_wdata_q  <= '0;
            sprite_wvalid_q <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            commit_cnt_q    <= commit_cnt_d;
            in_vblank_q     <= in_vblank;
            overflow_q      <= overflow_d;
            sprite_wdata_q  <= sprite_wdata_d;
            sprite_wvalid_q <= sprite_wvalid_d;
            frame_done_q    <= frame_done_d;
        end
    end

    // Next-state logic for the scheduler and its committed-word counter.
    always_comb begin
        state_d      = state_q;
        commit_cnt_d = commit_cnt_q - CNT_W'(pop);
        frame_done_d = 1'b0;
        if (commit_req) commit_cnt_d = cnt_after_pop;

        if (flush_req) begin
            state_d      = IDLE;
            commit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A commit inside vblank starts draining without waiting a frame.
                    if (commit_req && (cnt_after_pop != '0))
                        state_d = in_vblank ? DRAIN : ARMED;
                end
                ARMED: begin
                    if (vb_rise || (commit_req && in_vblank))
                        state_d = DRAIN;
                end
                DRAIN: begin
                    if (commit_cnt_d == '0) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end else if (!in_vblank) begin
                        // Active video resumed: the remainder waits for the next vblank.
                        state_d = ARMED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: registered broadcast port, sticky overflow, busy flag.
    always_comb begin
        sprite_wvalid_d = pop;
        sprite_wdata_d  = pop ? fifo_dout : sprite_wdata_q;
        overflow_d      = overflow_q;
        if (flush_req)
            overflow_d = 1'b0;
        else if (push_req && !push_ok)
            overflow_d = 1'b1;
    end

    assign busy          = (state_q != IDLE);
    assign overflow      = overflow_q;
    assign sprite_wdata  = sprite_wdata_q;
    assign sprite_wvalid = sprite_wvalid_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_sprite_cmd_sched.sv
// Directed bench for sprite_cmd_sched: a vector table for the basic batch
// and held-word cases, then hand-written sequences for overflow, a vblank
// cut mid-drain, commit inside vblank and reset during a drain.
module tb_sprite_cmd_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] sprite_wdata;
    logic        sprite_wvalid;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [9:0]  vc;
        logic        ewv;
        logic [31:0] ewd;
        logic [4:0]  elvl;
        logic        ebusy;
        logic        edone;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    sprite_cmd_sched dut (
        .clk           (clk),
        .reset         (reset),
        .chipselect    (chipselect),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .hcount        (hcount),
        .vcount        (vcount),
        .sprite_wdata  (sprite_wdata),
        .sprite_wvalid (sprite_wvalid),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    function automatic vec_t v(input logic cs, input logic wr, input logic [2:0] addr,
                               input logic [31:0] data, input logic [9:0] vc,
                               input logic ewv, input logic [31:0] ewd, input logic [4:0] elvl,
                               input logic ebusy, input logic edone, input logic eovf);
        vec_t r;
        r.cs = cs; r.wr = wr; r.addr = addr; r.data = data; r.vc = vc;
        r.ewv = ewv; r.ewd = ewd; r.elvl = elvl;
        r.ebusy = ebusy; r.edone = edone; r.eovf = eovf;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic wr, input logic [2:0] addr,
                         input logic [31:0] data, input logic [9:0] vc);
        chipselect = cs;
        write      = wr;
        address    = addr;
        writedata  = data;
        vcount     = vc;
    endtask

    task automatic cyc(input logic cs, input logic wr, input logic [2:0] addr,
                       input logic [31:0] data, input logic [9:0] vc);
        drive(cs, wr, addr, data, vc);
        step();
    endtask

    task automatic push(input logic [31:0] d, input logic [9:0] vc);
        cyc(1'b1, 1'b1, 3'd0, d, vc);
    endtask

    task automatic idle(input logic [9:0] vc);
        cyc(1'b0, 1'b0, 3'd0, 32'h0, vc);
    endtask

    initial begin
        reset = 1'b1;
        hcount = 10'd123;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 10'd100);

        // Basic batch: three words committed in active video, released in vblank.
        tbl.push_back(v(1,1,0,32'hA0000001,100, 0,32'h0,1,0,0,0));
        tbl.push_back(v(0,1,0,32'hDEADBEEF,100, 0,32'h0,1,0,0,0));
        tbl.push_back(v(1,0,0,32'hDEADBEEF,100, 0,32'h0,1,0,0,0));
        tbl.push_back(v(1,1,0,32'hA0000002,100, 0,32'h0,2,0,0,0));
        tbl.push_back(v(1,1,0,32'hA0000003,100, 0,32'h0,3,0,0,0));
        tbl.push_back(v(1,1,1,32'h0,100, 0,32'h0,3,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,100, 0,32'h0,3,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 0,32'h0,3,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 1,32'hA0000001,2,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 1,32'hA0000002,1,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 1,32'hA0000003,0,0,1,0));
        tbl.push_back(v(0,0,0,32'h0,480, 0,32'hA0000003,0,0,0,0));
        tbl.push_back(v(0,0,0,32'h0,100, 0,32'hA0000003,0,0,0,0));
        tbl.push_back(v(1,1,3,32'h12345678,100, 0,32'hA0000003,0,0,0,0));
        // Post-commit writes are held until a later commit.
        tbl.push_back(v(1,1,0,32'hB0000001,100, 0,32'hA0000003,1,0,0,0));
        tbl.push_back(v(1,1,0,32'hB0000002,100, 0,32'hA0000003,2,0,0,0));
        tbl.push_back(v(1,1,1,32'h0,100, 0,32'hA0000003,2,1,0,0));
        tbl.push_back(v(1,1,0,32'hB0000009,100, 0,32'hA0000003,3,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 0,32'hA0000003,3,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 1,32'hB0000001,2,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 1,32'hB0000002,1,0,1,0));
        tbl.push_back(v(0,0,0,32'h0,480, 0,32'hB0000002,1,0,0,0));
        tbl.push_back(v(0,0,0,32'h0,100, 0,32'hB0000002,1,0,0,0));
        tbl.push_back(v(1,1,1,32'h0,100, 0,32'hB0000002,1,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 0,32'hB0000002,1,1,0,0));
        tbl.push_back(v(0,0,0,32'h0,480, 1,32'hB0000009,0,0,1,0));
        tbl.push_back(v(0,0,0,32'h0,480, 0,32'hB0000009,0,0,0,0));
        tbl.push_back(v(0,0,0,32'h0,100, 0,32'hB0000009,0,0,0,0));

        // Reset state.
        step();
        step();
        check("rst_wvalid", 32'(sprite_wvalid), 32'd0);
        check("rst_wdata",  sprite_wdata,       32'd0);
        check("rst_level",  32'(fifo_level),    32'd0);
        check("rst_ovf",    32'(overflow),      32'd0);
        check("rst_busy",   32'(busy),          32'd0);
        check("rst_done",   32'(frame_done),    32'd0);
        reset = 1'b0;

        // Table-driven vectors; expectations describe outputs after the edge.
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].cs, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].vc);
            check($sformatf("v%0d_wvalid", i), 32'(sprite_wvalid), 32'(tbl[i].ewv));
            check($sformatf("v%0d_wdata", i),  sprite_wdata,       tbl[i].ewd);
            check($sformatf("v%0d_level", i),  32'(fifo_level),    32'(tbl[i].elvl));
            check($sformatf("v%0d_busy", i),   32'(busy),          32'(tbl[i].ebusy));
            check($sformatf("v%0d_done", i),   32'(frame_done),    32'(tbl[i].edone));
            check($sformatf("v%0d_ovf", i),    32'(overflow),      32'(tbl[i].eovf));
        end

        // Overflow: 17 pushes into 16 entries, then flush.
        for (int i = 0; i < 17; i++) begin
            push(32'hC0000000 + 32'(i), 10'd100);
            if (i == 15) check("ovf_pre_flag", 32'(overflow), 32'd0);
        end
        check("ovf_level", 32'(fifo_level), 32'd16);
        check("ovf_flag",  32'(overflow),   32'd1);
        cyc(1'b1, 1'b1, 3'd1, 32'h0, 10'd100);
        check("ovf_commit_busy", 32'(busy), 32'd1);
        cyc(1'b1, 1'b1, 3'd2, 32'h0, 10'd100);
        check("flush_level", 32'(fifo_level), 32'd0);
        check("flush_ovf",   32'(overflow),   32'd0);
        check("flush_busy",  32'(busy),       32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(10'd480);
            check($sformatf("flush_vb%0d_wvalid", i), 32'(sprite_wvalid), 32'd0);
        end
        idle(10'd100);

        // Vblank cut mid-drain: 16 committed, 5 popped, rest at next vblank.
        for (int i = 0; i < 16; i++) push(32'hD0000000 + 32'(i), 10'd100);
        cyc(1'b1, 1'b1, 3'd1, 32'h0, 10'd100);
        idle(10'd480);
        check("cut_rise_wvalid", 32'(sprite_wvalid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            idle(10'd480);
            check($sformatf("cut_a%0d_wvalid", i), 32'(sprite_wvalid), 32'd1);
            check($sformatf("cut_a%0d_wdata", i),  sprite_wdata, 32'hD0000000 + 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            idle(10'd0);
            check($sformatf("cut_hold%0d_wvalid", i), 32'(sprite_wvalid), 32'd0);
            check($sformatf("cut_hold%0d_level", i),  32'(fifo_level),    32'd11);
            check($sformatf("cut_hold%0d_busy", i),   32'(busy),          32'd1);
        end
        idle(10'd480);
        check("cut_rise2_wvalid", 32'(sprite_wvalid), 32'd0);
        for (int i = 5; i < 16; i++) begin
            idle(10'd480);
            check($sformatf("cut_b%0d_wvalid", i), 32'(sprite_wvalid), 32'd1);
            check($sformatf("cut_b%0d_wdata", i),  sprite_wdata, 32'hD0000000 + 32'(i));
            check($sformatf("cut_b%0d_done", i),   32'(frame_done), (i == 15) ? 32'd1 : 32'd0);
        end
        check("cut_end_level", 32'(fifo_level), 32'd0);
        check("cut_end_busy",  32'(busy),       32'd0);
        idle(10'd480);
        check("cut_post_done", 32'(frame_done), 32'd0);

        // Commit inside vblank while IDLE, with a push alongside a pop.
        push(32'hE0000000, 10'd500);
        push(32'hE0000001, 10'd500);
        check("vbc_idle_wvalid", 32'(sprite_wvalid), 32'd0);
        check("vbc_idle_level",  32'(fifo_level),    32'd2);
        cyc(1'b1, 1'b1, 3'd1, 32'h0, 10'd500);
        check("vbc_commit_busy", 32'(busy), 32'd1);
        push(32'hE0000002, 10'd500);
        check("vbc_pp_wvalid", 32'(sprite_wvalid), 32'd1);
        check("vbc_pp_wdata",  sprite_wdata,       32'hE0000000);
        check("vbc_pp_level",  32'(fifo_level),    32'd2);
        idle(10'd500);
        check("vbc_last_wdata", sprite_wdata,    32'hE0000001);
        check("vbc_last_done",  32'(frame_done), 32'd1);
        check("vbc_last_level", 32'(fifo_level), 32'd1);
        check("vbc_last_busy",  32'(busy),       32'd0);
        idle(10'd500);
        check("vbc_after_wvalid", 32'(sprite_wvalid), 32'd0);
        cyc(1'b1, 1'b1, 3'd2, 32'h0, 10'd500);
        check("vbc_flush_level", 32'(fifo_level), 32'd0);
        idle(10'd100);

        // Reset during a drain.
        for (int i = 0; i < 4; i++) push(32'hF0000000 + 32'(i), 10'd100);
        cyc(1'b1, 1'b1, 3'd1, 32'h0, 10'd100);
        idle(10'd480);
        idle(10'd480);
        check("rd_f0_wdata", sprite_wdata, 32'hF0000000);
        idle(10'd480);
        check("rd_f1_wdata", sprite_wdata, 32'hF0000001);
        reset = 1'b1;
        idle(10'd480);
        check("rd_rst_wvalid", 32'(sprite_wvalid), 32'd0);
        check("rd_rst_wdata",  sprite_wdata,       32'd0);
        check("rd_rst_level",  32'(fifo_level),    32'd0);
        check("rd_rst_busy",   32'(busy),          32'd0);
        check("rd_rst_done",   32'(frame_done),    32'd0);
        reset = 1'b0;
        idle(10'd100);
        for (int i = 0; i < 4; i++) begin
            idle(10'd480);
            check($sformatf("rd_vb%0d_wvalid", i), 32'(sprite_wvalid), 32'd0);
            check($sformatf("rd_vb%0d_busy", i),   32'(busy),          32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
